// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// small decode helpers used by both the top level and the iterative core.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_SLL    = 4'b0010,
    OP_SLTU   = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_OR     = 4'b0110,
    OP_AND    = 4'b0111,
    OP_MUL    = 4'b1000,
    OP_MULH   = 4'b1001,
    OP_MULHSU = 4'b1010,
    OP_MULHU  = 4'b1011,
    OP_DIV    = 4'b1100,
    OP_DIVU   = 4'b1101,
    OP_REM    = 4'b1110,
    OP_REMU   = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Operand a is treated as signed for the high-multiply and signed divide ops.
  function automatic logic op_signed_a(input op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  // Operand b is signed only when both operands are.
  function automatic logic op_signed_b(input op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide datapath. Works on operand magnitudes, one bit per
// step, and applies the sign fix-up combinationally on the final step so the
// parent can register the finished result on the same edge.
module mdu_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic            hi_sel,
  input  logic            rem_sel,
  input  logic            neg_res,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            last,
  output logic [XLEN-1:0] res_fixed
);

  localparam int CW = $clog2(XLEN);

  // acc holds the product high half / partial remainder,
  // mq holds the multiplier / dividend shifting into the quotient.
  logic [XLEN-1:0]   acc_q, mq_q, opnd_q;
  logic [CW-1:0]     cnt_q;
  logic              div_q, hi_q, rem_q, neg_q;

  logic [XLEN-1:0]   acc_n, mq_n;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   qr_sel;

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin
    acc_n   = acc_q;
    mq_n    = mq_q;
    shifted = {acc_q, mq_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    if (div_q) begin
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        mq_n  = {mq_q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        mq_n  = {mq_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {acc_n, mq_n} = {sum, mq_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the post-step values.
  always_comb begin
    prod      = {acc_n, mq_n};
    prod_s    = neg_q ? -prod : prod;
    qr_sel    = rem_q ? acc_n : mq_n;
    if (div_q)
      res_fixed = neg_q ? -qr_sel : qr_sel;
    else
      res_fixed = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    last      = step && (cnt_q == CW'(XLEN - 1));
  end

  // Operand latch on start, then one step per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else if (flush) begin
      cnt_q  <= '0;
    end else if (start) begin
      acc_q  <= '0;
      mq_q   <= a_mag;
      opnd_q <= b_mag;
      cnt_q  <= '0;
      div_q  <= is_div;
      hi_q   <= hi_sel;
      rem_q  <= rem_sel;
      neg_q  <= neg_res;
    end else if (step) begin
      acc_q  <= acc_n;
      mq_q   <= mq_n;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle execute-stage ALU: single-cycle base ops and divide corner
// cases resolve in IDLE; multiply/divide run through mdu_iter_core.
//
//   state | meaning
//   IDLE  | ready for a new op (in_ready=1)
//   BUSY  | iterative mul/div in progress, one bit per cycle
//   DONE  | result registered, out_valid=1 until out_ready
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  op_e             op_sel;
  logic [XLEN-1:0] alu_res, spec_res, res_d, core_res, a_mag, b_mag;
  logic            a_s, b_s, div_zero, div_ovf, special, neg_res;
  logic            start, step, load, last;

  assign op_sel = op_e'(op);

  // Base ALU ops plus the divide corner cases that never need iteration.
  always_comb begin
    alu_res  = '0;
    div_zero = (b == '0);
    div_ovf  = (a == INT_MIN) && (&b) && !op[0];
    special  = op[3] && op[2] && (div_zero || div_ovf);
    if (op[1])
      spec_res = div_zero ? a : '0;
    else
      spec_res = div_zero ? '1 : a;
    case (op_sel)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = spec_res;
    endcase
  end

  // Operand magnitudes and result sign for the iterative core.
  always_comb begin
    a_s     = op_signed_a(op_sel) && a[XLEN-1];
    b_s     = op_signed_b(op_sel) && b[XLEN-1];
    a_mag   = a_s ? -a : a;
    b_mag   = b_s ? -b : b;
    // Remainder follows the dividend; quotient and product follow both signs.
    neg_res = (op[2] && op[1]) ? a_s : (a_s ^ b_s);
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (start),
    .step      (step),
    .is_div    (op[2]),
    .hi_sel    (op[1:0] != 2'b00),
    .rem_sel   (op[1]),
    .neg_res   (neg_res),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .last      (last),
    .res_fixed (core_res)
  );

  // Next-state and control; flush overrides everything else.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    load      = 1'b0;
    res_d     = alu_res;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    step      = (state_q == ST_BUSY) && !flush;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!op[3] || special) begin
            load    = 1'b1;
            state_d = ST_DONE;
          end else begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (last) begin
          load    = 1'b1;
          res_d   = core_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      start   = 1'b0;
      load    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Result register; only written when a result completes, so it holds in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    result <= '0;
    else if (load) result <= res_d;
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: a 32-bit instance for most scenarios and a
// 16-bit instance for the narrow-build multiply.
module tb_alu_seq_unit;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLL = 4'b0010, SLTU = 4'b0011;
  localparam logic [3:0] XOR = 4'b0100, SRL = 4'b0101, OR_ = 4'b0110, AND_ = 4'b0111;
  localparam logic [3:0] MUL = 4'b1000, MULH = 4'b1001, MULHSU = 4'b1010, MULHU = 4'b1011;
  localparam logic [3:0] DIV = 4'b1100, DIVU = 4'b1101, REM = 4'b1110, REMU = 4'b1111;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] a = 0, b = 0, result;
  logic [3:0]  op = 0;

  logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0;
  logic        flush16 = 0;
  logic [15:0] a16 = 0, b16 = 0, result16;
  logic [3:0]  op16 = 0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  alu_seq_unit #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .flush(flush16), .out_valid(out_valid16),
    .out_ready(out_ready16), .result(result16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Stimulus only: present one op, return latency in cycles and the result.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] r);
    int guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    op = o; a = x; b = y; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    r = result;
  endtask

  task automatic run_op16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output logic [15:0] r);
    int guard = 0;
    while (!in_ready16 && guard < 200) begin @(negedge clk); guard++; end
    op16 = o; a16 = x; b16 = y; in_valid16 = 1;
    @(negedge clk);
    in_valid16 = 0;
    lat = 1;
    while (!out_valid16 && lat < 200) begin @(negedge clk); lat++; end
    r = result16;
  endtask

  task automatic accept();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    int lat;
    logic [31:0] r;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, r);
      n_checks++;
      if (r !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s[%0d] result: got %h expected %h", name, i, r, v[i].exp);
      end
      n_checks++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, v[i].lat);
      end
      accept();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h expected 0", result); end
    n_checks++;
    if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid16: got %b expected 0", out_valid16); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_cycle();
    vec_t v[] = '{
      '{ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1},
      '{SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1},
      '{SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1},
      '{SLTU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1},
      '{SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1},
      '{XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1},
      '{SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1},
      '{OR_,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1},
      '{AND_, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1}
    };
    run_table("single", v);
  endtask

  task automatic test_mul();
    vec_t v[] = '{
      '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
      '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33},
      '{MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33}
    };
    run_table("mul", v);
  endtask

  task automatic test_div();
    vec_t v[] = '{
      '{DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
      '{REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
      '{DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
      '{REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33},
      '{DIVU, 32'd100,       32'd7,         32'd14,        33},
      '{REMU, 32'd100,       32'd7,         32'd2,         33},
      '{DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{REMU, 32'd9,         32'd0,         32'd9,         1},
      '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
    };
    run_table("div", v);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r;
    run_op(MUL, 32'd6, 32'd7, lat, r);
    n_checks++;
    if (r !== 32'd42 || lat !== 33) begin
      n_fail++; $display("FAIL bp_mul: got %0d lat %0d expected 42 lat 33", r, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (result !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: result %0d out_valid %b in_ready %b expected 42 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    accept();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready %b out_valid %b expected 1 0", in_ready, out_valid);
    end
    op = ADD; a = 32'h10; b = 32'h20; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'h30) begin
      n_fail++; $display("FAIL bp_next: out_valid %b result %h expected 1 00000030", out_valid, result);
    end
    accept();
  endtask

  task automatic test_flush();
    int lat;
    int seen = 0;
    logic [31:0] r;
    op = DIVU; a = 32'd1000; b = 32'd3; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: in_ready %b out_valid %b expected 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_result: out_valid cycles %0d expected 0", seen); end
    run_op(ADD, 32'd2, 32'd3, lat, r);
    n_checks++;
    if (r !== 32'd5 || lat !== 1) begin
      n_fail++; $display("FAIL flush_add: got %0d lat %0d expected 5 lat 1", r, lat);
    end
    accept();
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    op = MUL; a = 32'd6; b = 32'd7; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: out_valid %b result %h expected 0 00000000", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: in_ready %b expected 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_result: out_valid cycles %0d expected 0", seen); end
  endtask

  task automatic test_xlen16();
    int lat;
    logic [15:0] r;
    run_op16(MUL, 16'h00FF, 16'h0101, lat, r);
    n_checks++;
    if (r !== 16'hFFFF || lat !== 17) begin
      n_fail++; $display("FAIL x16_mul: got %h lat %0d expected ffff lat 17", r, lat);
    end
    out_ready16 = 1; @(negedge clk); out_ready16 = 0;
    run_op16(MULHU, 16'hFFFF, 16'hFFFF, lat, r);
    n_checks++;
    if (r !== 16'hFFFE || lat !== 17) begin
      n_fail++; $display("FAIL x16_mulhu: got %h lat %0d expected fffe lat 17", r, lat);
    end
    out_ready16 = 1; @(negedge clk); out_ready16 = 0;
    run_op16(DIV, 16'hFFF9, 16'h0002, lat, r);
    n_checks++;
    if (r !== 16'hFFFD || lat !== 17) begin
      n_fail++; $display("FAIL x16_div: got %h lat %0d expected fffd lat 17", r, lat);
    end
    out_ready16 = 1; @(negedge clk); out_ready16 = 0;
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    test_xlen16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
